// File: rtl/selector_driver.sv
// Stimulus-and-check initiator for the 4:1 complementary-output selector.
// Sweeps all 16 sel/a/b vectors, samples q/nq after SETTLE cycles and tallies mismatches.
module selector_driver #(
   parameter int SETTLE = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic [1:0] sel,
   output logic       a,
   output logic       b,
   input  logic       q,
   input  logic       nq,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [4:0] err_count,
   output logic       first_err_valid,
   output logic [3:0] first_err_vec
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   state_t     state, state_nx;
   logic [3:0] v, v_nx;
   logic [3:0] cnt, cnt_nx;
   logic [3:0] drive, drive_nx;
   logic       busy_nx, done_nx, pass_nx;
   logic [4:0] err_nx;
   logic       fev_nx;
   logic [3:0] fvec_nx;
   logic       expv;
   logic       mismatch;
   logic       sample_edge;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   assign sample_edge = (state == RUN) && (cnt == SETTLE_LAST);

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (sample_edge && (v == 4'd15)) state_nx = DONE;
         DONE:    if (start) state_nx = RUN;
         default: state_nx = IDLE;
      endcase
   end

   // Expected selector function for the vector currently being driven
   always_comb begin
      expv = 1'b0;
      case (v[3:2])
         2'b00:   expv = v[1];
         2'b01:   expv = v[0];
         2'b10:   expv = v[1] & v[0];
         default: expv = v[1] | v[0];
      endcase
   end

   assign mismatch = (q != expv) || (nq != ~expv);

   // Next values for every registered output and the sweep datapath
   always_comb begin
      v_nx     = v;
      cnt_nx   = cnt;
      drive_nx = 4'd0;
      busy_nx  = 1'b0;
      done_nx  = 1'b0;
      pass_nx  = pass;
      err_nx   = err_count;
      fev_nx   = first_err_valid;
      fvec_nx  = first_err_vec;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               v_nx     = 4'd0;
               cnt_nx   = 4'd0;
               drive_nx = 4'd0;
               busy_nx  = 1'b1;
               pass_nx  = 1'b0;
               err_nx   = 5'd0;
               fev_nx   = 1'b0;
               fvec_nx  = 4'd0;
            end else begin
               done_nx = (state == DONE);
            end
         end
         RUN: begin
            busy_nx  = 1'b1;
            drive_nx = v;
            if (sample_edge) begin
               cnt_nx = 4'd0;
               if (mismatch) begin
                  err_nx = err_count + 5'd1;
                  if (!first_err_valid) begin
                     fev_nx  = 1'b1;
                     fvec_nx = v;
                  end
               end
               if (v == 4'd15) begin
                  busy_nx  = 1'b0;
                  done_nx  = 1'b1;
                  drive_nx = 4'd0;
                  pass_nx  = (err_nx == 5'd0);
               end else begin
                  v_nx     = v + 4'd1;
                  drive_nx = v + 4'd1;
               end
            end else begin
               cnt_nx = cnt + 4'd1;
            end
         end
         default: ;
      endcase
   end

   // Output and datapath registers; q/nq only reach outputs through here
   always_ff @(posedge clk) begin
      if (rst) begin
         v               <= 4'd0;
         cnt             <= 4'd0;
         drive           <= 4'd0;
         busy            <= 1'b0;
         done            <= 1'b0;
         pass            <= 1'b0;
         err_count       <= 5'd0;
         first_err_valid <= 1'b0;
         first_err_vec   <= 4'd0;
      end else begin
         v               <= v_nx;
         cnt             <= cnt_nx;
         drive           <= drive_nx;
         busy            <= busy_nx;
         done            <= done_nx;
         pass            <= pass_nx;
         err_count       <= err_nx;
         first_err_valid <= fev_nx;
         first_err_vec   <= fvec_nx;
      end
   end

   assign sel = drive[3:2];
   assign a   = drive[1];
   assign b   = drive[0];

endmodule

// File: tb/tb_selector_driver.sv
// Directed bench for selector_driver: one instance with SETTLE=1 and a faultable selector model,
// one with SETTLE=3 fed by a two-cycle-delayed selector model.
module tb_selector_driver;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   int         total = 0;
   int         bad = 0;

   logic       start1 = 1'b0;
   logic [1:0] sel1;
   logic       a1, b1, q1, nq1;
   logic       busy1, done1, pass1, fev1;
   logic [4:0] err1;
   logic [3:0] fvec1;
   int         mode = 0;

   logic       start2 = 1'b0;
   logic [1:0] sel2;
   logic       a2, b2;
   logic       busy2, done2, pass2, fev2;
   logic [4:0] err2;
   logic [3:0] fvec2;
   logic       d1q, d1nq, d2q, d2nq;

   always #5 clk = ~clk;

   selector_driver #(.SETTLE(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .sel(sel1), .a(a1), .b(b1),
      .q(q1), .nq(nq1), .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1), .first_err_valid(fev1), .first_err_vec(fvec1)
   );

   selector_driver #(.SETTLE(3)) dut3 (
      .clk(clk), .rst(rst), .start(start2), .sel(sel2), .a(a2), .b(b2),
      .q(d2q), .nq(d2nq), .busy(busy2), .done(done2), .pass(pass2),
      .err_count(err2), .first_err_valid(fev2), .first_err_vec(fvec2)
   );

   function automatic logic sel_model(input logic [1:0] s, input logic x, input logic y);
      case (s)
         2'b00:   return x;
         2'b01:   return y;
         2'b10:   return x & y;
         default: return x | y;
      endcase
   endfunction

   // Mode 0: healthy selector, 1: q stuck at 0, 2: nq not inverted
   always_comb begin
      q1  = sel_model(sel1, a1, b1);
      nq1 = ~q1;
      if (mode == 1) q1 = 1'b0;
      if (mode == 2) nq1 = q1;
   end

   always @(posedge clk) begin
      d1q  <= sel_model(sel2, a2, b2);
      d1nq <= ~sel_model(sel2, a2, b2);
      d2q  <= d1q;
      d2nq <= d1nq;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      total++;
      if ({sel1, a1, b1, busy1, done1, pass1, err1, fev1, fvec1} !== 17'd0) begin
         bad++;
         $display("[TB] FAIL reset_outputs1: got %b required all zero",
                  {sel1, a1, b1, busy1, done1, pass1, err1, fev1, fvec1});
      end
      total++;
      if ({sel2, a2, b2, busy2, done2, pass2, err2, fev2, fvec2} !== 17'd0) begin
         bad++;
         $display("[TB] FAIL reset_outputs3: got %b required all zero",
                  {sel2, a2, b2, busy2, done2, pass2, err2, fev2, fvec2});
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_clean_sweep();
      mode = 0;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int n = 0; n < 16; n++) begin
         total++;
         if ({sel1, a1, b1} !== 4'(n) || busy1 !== 1'b1 || done1 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL clean_vec%0d: got vec=%0d busy=%b done=%b required vec=%0d busy=1 done=0",
                     n, {sel1, a1, b1}, busy1, done1, n);
         end
         tick();
      end
      total++;
      if (done1 !== 1'b1 || busy1 !== 1'b0 || pass1 !== 1'b1 || err1 !== 5'd0 || fev1 !== 1'b0
          || {sel1, a1, b1} !== 4'd0) begin
         bad++;
         $display("[TB] FAIL clean_done: got done=%b busy=%b pass=%b err=%0d fev=%b vec=%0d required 1 0 1 0 0 0",
                  done1, busy1, pass1, err1, fev1, {sel1, a1, b1});
      end
   endtask

   task automatic test_q_stuck();
      mode = 1;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      tick();
      tick();
      total++;
      if (err1 !== 5'd0 || fev1 !== 1'b0) begin
         bad++;
         $display("[TB] FAIL qstuck_before_first: got err=%0d fev=%b required 0 0", err1, fev1);
      end
      tick();
      total++;
      if (err1 !== 5'd1 || fev1 !== 1'b1 || fvec1 !== 4'd2) begin
         bad++;
         $display("[TB] FAIL qstuck_first_edge: got err=%0d fev=%b fvec=%0d required 1 1 2", err1, fev1, fvec1);
      end
      for (int n = 3; n < 16; n++) tick();
      total++;
      if (done1 !== 1'b1 || err1 !== 5'd8 || fvec1 !== 4'd2 || fev1 !== 1'b1 || pass1 !== 1'b0) begin
         bad++;
         $display("[TB] FAIL qstuck_done: got done=%b err=%0d fvec=%0d fev=%b pass=%b required 1 8 2 1 0",
                  done1, err1, fvec1, fev1, pass1);
      end
   endtask

   task automatic test_nq_noninv();
      mode = 2;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int n = 0; n < 16; n++) tick();
      total++;
      if (done1 !== 1'b1 || err1 !== 5'd16 || fvec1 !== 4'd0 || fev1 !== 1'b1 || pass1 !== 1'b0) begin
         bad++;
         $display("[TB] FAIL nq_noninv_done: got done=%b err=%0d fvec=%0d fev=%b pass=%b required 1 16 0 1 0",
                  done1, err1, fvec1, fev1, pass1);
      end
   endtask

   task automatic test_restart_after_fail();
      mode = 0;
      tick();
      total++;
      if (done1 !== 1'b1 || err1 !== 5'd16) begin
         bad++;
         $display("[TB] FAIL done_held: got done=%b err=%0d required 1 16", done1, err1);
      end
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      total++;
      if (err1 !== 5'd0 || fev1 !== 1'b0 || fvec1 !== 4'd0 || busy1 !== 1'b1 || done1 !== 1'b0) begin
         bad++;
         $display("[TB] FAIL restart_clear: got err=%0d fev=%b fvec=%0d busy=%b done=%b required 0 0 0 1 0",
                  err1, fev1, fvec1, busy1, done1);
      end
      for (int n = 0; n < 16; n++) tick();
      total++;
      if (done1 !== 1'b1 || pass1 !== 1'b1 || err1 !== 5'd0) begin
         bad++;
         $display("[TB] FAIL restart_done: got done=%b pass=%b err=%0d required 1 1 0", done1, pass1, err1);
      end
   endtask

   task automatic test_start_held();
      int done_cycles;
      mode = 0;
      start1 = 1'b1;
      tick();
      for (int n = 0; n < 16; n++) begin
         total++;
         if ({sel1, a1, b1} !== 4'(n) || busy1 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL held_vec%0d: got vec=%0d busy=%b required vec=%0d busy=1",
                     n, {sel1, a1, b1}, busy1, n);
         end
         tick();
      end
      done_cycles = 0;
      for (int n = 0; n < 4; n++) begin
         if (done1 === 1'b1) done_cycles++;
         tick();
      end
      total++;
      if (done_cycles != 1) begin
         bad++;
         $display("[TB] FAIL held_done_width: got %0d cycles required 1", done_cycles);
      end
      start1 = 1'b0;
      total++;
      if (busy1 !== 1'b1 || {sel1, a1, b1} !== 4'd3) begin
         bad++;
         $display("[TB] FAIL held_resweep: got busy=%b vec=%0d required busy=1 vec=3", busy1, {sel1, a1, b1});
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset_mid();
      int done_seen;
      mode = 0;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int n = 0; n < 6; n++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if ({sel1, a1, b1, busy1, done1, pass1, err1, fev1, fvec1} !== 17'd0) begin
         bad++;
         $display("[TB] FAIL midreset_outputs: got %b required all zero",
                  {sel1, a1, b1, busy1, done1, pass1, err1, fev1, fvec1});
      end
      done_seen = 0;
      for (int n = 0; n < 20; n++) begin
         if (done1 !== 1'b0 || busy1 !== 1'b0) done_seen++;
         tick();
      end
      total++;
      if (done_seen != 0) begin
         bad++;
         $display("[TB] FAIL midreset_no_done: got %0d active cycles required 0", done_seen);
      end
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int n = 0; n < 16; n++) tick();
      total++;
      if (done1 !== 1'b1 || pass1 !== 1'b1 || err1 !== 5'd0) begin
         bad++;
         $display("[TB] FAIL midreset_resweep: got done=%b pass=%b err=%0d required 1 1 0", done1, pass1, err1);
      end
   endtask

   task automatic test_settle3();
      int errs;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      errs = 0;
      for (int c = 0; c < 48; c++) begin
         if ({sel2, a2, b2} !== 4'(c / 3) || busy2 !== 1'b1 || done2 !== 1'b0) begin
            errs++;
            $display("[TB] FAIL settle3_cycle%0d: got vec=%0d busy=%b done=%b required vec=%0d busy=1 done=0",
                     c, {sel2, a2, b2}, busy2, done2, c / 3);
         end
         tick();
      end
      total++;
      if (errs != 0) bad++;
      total++;
      if (done2 !== 1'b1 || busy2 !== 1'b0 || pass2 !== 1'b1 || err2 !== 5'd0 || fev2 !== 1'b0) begin
         bad++;
         $display("[TB] FAIL settle3_done: got done=%b busy=%b pass=%b err=%0d fev=%b required 1 0 1 0 0",
                  done2, busy2, pass2, err2, fev2);
      end
   endtask

   initial begin
      $display("[TB] selector_driver bench starting");
      test_reset();
      test_clean_sweep();
      test_q_stuck();
      test_nq_noninv();
      test_restart_after_fail();
      test_settle3();
      test_start_held();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/selector_driver.md
# selector_driver

Self-checking initiator for the 4:1 selector block with complementary outputs. It sweeps all 16 combinations of `sel`, `a` and `b`, and drives them onto the selector's inputs. After a programmable settle time it samples the selector's `Q`/`NQ` pair and compares it against the expected function. It then reports a pass/fail result, an error count and the first failing vector. It sits next to the selector in example/simulation top levels as the stimulus-and-check end of that interface.

## Interface
Parameters:
- `SETTLE`, default 1: cycles each vector is held before its response is sampled. Legal range 1..15.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a sweep; sampled only in IDLE or DONE.
- `sel`  out  2  selector select drive.
- `a`  out  1  selector operand a drive.
- `b`  out  1  selector operand b drive.
- `q`  in  1  selector Q response.
- `nq`  in  1  selector NQ response.
- `busy`  out  1  sweep in progress.
- `done`  out  1  sweep finished; held until restart or reset.
- `pass`  out  1  valid when `done` is high; 1 iff `err_count` is 0.
- `err_count`  out  5  number of mismatching vectors, 0..16.
- `first_err_valid`  out  1  at least one mismatch has been recorded.
- `first_err_vec`  out  4  index of the first mismatching vector.

## Operation
- Vector index `v[3:0]` maps to the selector inputs as `sel=v[3:2]`, `a=v[1]`, `b=v[0]`. The sweep order is `v` = 0..15.
- Expected response `exp` per `sel` value:
  - 00: `a`
  - 01: `b`
  - 10: `a&b`
  - 11: `a|b`
- A vector is a mismatch if `q != exp` or `nq != ~exp`. A vector with both outputs wrong counts once.
- State machine states: IDLE, RUN, DONE.
  - IDLE: `sel`/`a`/`b` = 0, `busy` = 0, `done` = 0. `start`=1 moves to RUN.
  - RUN: `busy` = 1. The current vector is driven; a settle counter counts SETTLE cycles. At the sample edge, `q`/`nq` are compared and the result is accumulated. If `v` < 15, `v` increments and the next vector is driven from that same edge. If `v` = 15, the block moves to DONE.
  - DONE: `done` = 1, `busy` = 0, `sel`/`a`/`b` = 0. `pass`, `err_count` and `first_err_*` are held. `start`=1 restarts the sweep as from IDLE.
- Starting a sweep clears `err_count`, `first_err_valid` and `first_err_vec` to 0 and sets `v` to 0.
- `start` is ignored during RUN.
- `first_err_vec` is written only on the first mismatch of a sweep, which is the same edge that sets `first_err_valid`.
- All outputs are registered. No combinational path exists from `q`/`nq` to any output.

## Timing
- Reset values: `sel`=0, `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_valid`=0, `first_err_vec`=0. State is IDLE.
- Reset mid-sweep: all outputs take their reset values at the reset edge. No `done` pulse occurs, and there is no partial result.
- If `start` is sampled at edge k:
  - Vector 0 is visible on `sel`/`a`/`b` from edge k.
  - `busy`=1 from edge k.
- Vector n is driven from edge k+n·SETTLE. Its response is sampled at edge k+(n+1)·SETTLE.
- `done`=1 and `busy`=0 from edge k+16·SETTLE. The total sweep length is 16·SETTLE cycles.
- `err_count` and `first_err_*` update at the sample edge of the failing vector.
- `start` held high continuously: one sweep runs, then a new sweep begins on the first edge in DONE. `done` is high for exactly 1 cycle in that case.

## Test plan
- Correct selector model, SETTLE=1, `start` pulsed at edge 0:
  - `sel`/`a`/`b` step through 0..15, one vector per cycle.
  - `done`=1 at edge 16 with `pass`=1, `err_count`=0, `first_err_valid`=0.
- `q` stuck at 0, `nq` correct:
  - `err_count`=8 (all vectors with `exp`=1).
  - `first_err_vec`=2 (`sel`=00, `a`=1, `b`=0).
  - `pass`=0.
- `nq` tied equal to `q` (no inversion), `q` correct:
  - `err_count`=16, `first_err_vec`=0, `pass`=0.
- SETTLE=3, correct model:
  - Each vector is held 3 cycles.
  - `done`=1 exactly 48 cycles after the start edge.
  - Sampling a 2-cycle-delayed model still yields `pass`=1.
- `rst` asserted on the 7th cycle of RUN:
  - At the next edge all outputs are 0 and `busy`=0.
  - `done` never asserts.
  - A subsequent `start` runs a full clean sweep.
- `start` held through RUN does not perturb the vector order. A `start` pulse in DONE after a failing run clears `err_count` to 0 and reruns the sweep.
